// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump sequencer.
package regfile_dump_pkg;

  localparam int WIDTH    = 32;
  localparam int REGNUM_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    CKSUM = 2'd3
  } state_e;

  // Register numbers wrap 31 -> 0.
  function automatic logic [REGNUM_W-1:0] next_reg(input logic [REGNUM_W-1:0] n);
    return n + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_dumper.sv
// Walks a wrapping range of register numbers through one register-file read port and
// streams the values over valid/ready. REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum word.
module regfile_dumper
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH    = regfile_dump_pkg::WIDTH,
  parameter int REGNUM_W = regfile_dump_pkg::REGNUM_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [REGNUM_W-1:0] first_reg,
  input  logic [REGNUM_W-1:0] last_reg,
  output logic [REGNUM_W-1:0] rd_regnum,
  input  logic [WIDTH-1:0]    rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [REGNUM_W-1:0] out_regnum,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [REGNUM_W-1:0] ptr_q, ptr_d;
  logic [REGNUM_W-1:0] last_q, last_d;
  logic [REGNUM_W-1:0] out_regnum_q, out_regnum_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic [REGNUM_W-1:0] ptr_nxt;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0]    acc_q, acc_d;
`endif

  assign ptr_nxt = next_reg(ptr_q);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    out_data_d   = out_data_q;
    out_regnum_d = out_regnum_q;
    out_last_d   = out_last_q;
    done_d       = 1'b0;
    rd_regnum    = ptr_q;
    out_valid    = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d        = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = first_reg;
          last_d  = last_reg;
          state_d = LOAD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      LOAD: begin
        out_data_d   = rd_data;
        out_regnum_d = ptr_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d   = 1'b0;
`else
        out_last_d   = (ptr_q == last_q);
`endif
        state_d      = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        // Address the next register now so its value is ready at the handshake edge.
        rd_regnum = ptr_nxt;
        if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d = acc_q ^ out_data_q;
`endif
          if (ptr_q != last_q) begin
            out_data_d   = rd_data;
            out_regnum_d = ptr_nxt;
            ptr_d        = ptr_nxt;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            out_last_d   = 1'b0;
`else
            out_last_d   = (ptr_nxt == last_q);
`endif
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_d      = CKSUM;
            out_data_d   = acc_q ^ out_data_q;
            out_regnum_d = last_q;
            out_last_d   = 1'b1;
`else
            state_d      = IDLE;
            done_d       = 1'b1;
`endif
          end
        end
      end
      CKSUM: begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      last_q       <= '0;
      out_data_q   <= '0;
      out_regnum_q <= '0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      out_data_q   <= out_data_d;
      out_regnum_q <= out_regnum_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q        <= acc_d;
`endif
    end
  end

  assign out_data   = out_data_q;
  assign out_regnum = out_regnum_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: stimulus pushes expected words, a negedge monitor checks them.
// Honours REGFILE_DUMP_CHECKSUM_EN so expectations match the build under test.
`timescale 1ns/1ps
module tb_regfile_dumper;

  localparam int W  = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [RW-1:0] regnum;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] first_reg = '0;
  logic [RW-1:0] last_reg = '0;
  logic [RW-1:0] rd_regnum;
  logic [W-1:0]  rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [RW-1:0] out_regnum;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [W-1:0]  regs [32];
  exp_t          sb [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int starts_issued = 0;
  int dumps_aborted = 0;
  int dumps_done = 0;
  int ready_mode = 0;

  regfile_dumper dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_regnum(rd_regnum), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_regnum(out_regnum), .out_last(out_last), .busy(busy), .done(done)
  );

  assign rd_data = regs[rd_regnum];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Sink readiness: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1.
  initial begin
    int pat;
    pat = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       begin out_ready = (pat == 0 || pat == 3); pat = (pat + 1) % 4; end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: handshakes pop the scoreboard; stalls, busy and done are checked every cycle.
  initial begin
    logic          prev_valid, prev_hs, prev_fin, prev_last, exp_done, hs, fin;
    logic [W-1:0]  prev_data;
    logic [RW-1:0] prev_regnum;
    exp_t          e;
    prev_valid = 0; prev_hs = 0; prev_fin = 0; prev_last = 0; exp_done = 0;
    prev_data = '0; prev_regnum = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 0; prev_hs = 0; prev_fin = 0; exp_done = 0;
      end else begin
        check("busy", busy, 32'(starts_issued != dumps_done + dumps_aborted));
        check("done", done, 32'(exp_done));
        exp_done = 0;
        if (prev_valid && !prev_hs) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, prev_data);
          check("stall_regnum", out_regnum, prev_regnum);
          check("stall_last", out_last, prev_last);
        end
        if (prev_hs && !prev_fin) check("next_word_valid", out_valid, 1);
        if (out_valid && !prev_valid) check("first_word_cycle", cyc, start_cyc + 1);
        hs  = out_valid && out_ready;
        fin = 0;
        if (hs) begin
          if (sb.size() == 0) begin
            check("word_expected", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            $display("[TB] word reg=%0d data=%h last=%b", out_regnum, out_data, out_last);
            check("out_data", out_data, e.data);
            check("out_regnum", out_regnum, e.regnum);
            check("out_last", out_last, e.last);
            if (e.last) begin
              fin = 1;
              exp_done = 1;
              dumps_done++;
            end
          end
        end
        prev_valid = out_valid; prev_hs = hs; prev_fin = fin;
        prev_data = out_data; prev_regnum = out_regnum; prev_last = out_last;
      end
    end
  end

  // Expected stream from the range rule: ((l-f) mod 32)+1 words starting at f, wrapping.
  task automatic push_expected(input logic [RW-1:0] f, input logic [RW-1:0] l);
    logic [RW-1:0] span;
    int            n;
    exp_t          e;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [W-1:0]  acc;
    acc = '0;
`endif
    span = l - f;
    n = int'(span) + 1;
    for (int k = 0; k < n; k++) begin
      logic [RW-1:0] r;
      r = f + RW'(k);
      e.data = regs[r];
      e.regnum = r;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      e.last = 1'b0;
      acc ^= regs[r];
`else
      e.last = (k == n - 1);
`endif
      sb.push_back(e);
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    e.data = acc;
    e.regnum = l;
    e.last = 1'b1;
    sb.push_back(e);
`endif
  endtask

  task automatic issue_dump(input logic [RW-1:0] f, input logic [RW-1:0] l);
    push_expected(f, l);
    first_reg = f;
    last_reg = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    starts_issued++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (starts_issued != dumps_done + dumps_aborted && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("dump_completes", 32'(starts_issued == dumps_done + dumps_aborted), 1);
    if (starts_issued != dumps_done + dumps_aborted) begin
      sb.delete();
      dumps_aborted = starts_issued - dumps_done;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111_1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_regnum", out_regnum, 0);
    check("rst_out_last", out_last, 0);
    check("rst_rd_regnum", rd_regnum, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full dump, wrapping range, single word.
    issue_dump(5'd0, 5'd31);
    wait_idle();
    issue_dump(5'd30, 5'd1);
    wait_idle();
    issue_dump(5'd7, 5'd7);
    wait_idle();

    // Backpressure pattern.
    ready_mode = 2;
    issue_dump(5'd3, 5'd9);
    wait_idle();
    ready_mode = 0;

    // Checksum-oriented values.
    regs[4] = 32'hF0F0_F0F0;
    regs[5] = 32'h0F0F_0F0F;
    regs[6] = 32'h0000_00FF;
    issue_dump(5'd4, 5'd6);
    wait_idle();

    // Reset in cycle 5 of a full dump with a new start held high.
    issue_dump(5'd0, 5'd31);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    first_reg = 5'd2;
    last_reg = 5'd3;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    dumps_aborted = starts_issued - dumps_done;
    push_expected(5'd2, 5'd3);
    @(negedge clk);
    check("post_reset_valid", out_valid, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_done", done, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    starts_issued++;
    wait_idle();

    // Random contents, ranges and sink behaviour; some dumps start in the done cycle.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      ready_mode = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
      issue_dump(RW'($urandom_range(0, 31)), RW'($urandom_range(0, 31)));
      wait_idle();
    end
    ready_mode = 0;

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
